twofish_cbc_ctrl: RTL

//  Block-mode controller directly upstream of the Twofish datapath. Accepts 128-bit blocks over a

---
 rtl/twofish_cbc_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/twofish_cbc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : twofish_cbc_ctrl
//  Brief    : CBC/ECB block-mode controller in front of a Twofish datapath.
//             Build with TWOFISH_CBC_EN defined for CBC chaining, else ECB.
//  Revision : 1.0
// ============================================================================
module twofish_cbc_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [127:0]      key,
   input  logic [127:0]      iv,
   input  logic              iv_load,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_block,
   input  logic              in_dec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_block,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              err_timeout,
   output logic              dp_rst,
   output logic              dp_start,
   output logic              dp_ende,
   output logic [127:0]      dp_block,
   output logic [127:0]      dp_key,
   output logic [ADDR_W-1:0] dp_addr,
   input  logic [127:0]      dp_o,
   input  logic              dp_busy
);

`ifdef TWOFISH_CBC_EN
   localparam logic CBC_EN = 1'b1;
`else
   localparam logic CBC_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ACK   = 3'd2,
      S_DONE  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t              state_q;
   logic [127:0]        chain_q;
   logic [127:0]        save_q;
   logic                dec_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                busy_q;
   logic                err_q;
   logic                dp_start_q;
   logic                dp_ende_q;
   logic [127:0]        dp_block_q;
   logic [127:0]        out_block_q;
   logic [ADDR_W-1:0]   out_addr_q;

   logic [127:0]        chain_d;
   logic [127:0]        dp_in_d;
   logic [127:0]        out_d;
   logic [127:0]        next_chain_d;
   logic                timeout_d;

   // An iv_load arriving with the accepted block wins: the block chains with the new iv.
   always_comb begin
      chain_d      = iv_load ? iv : chain_q;
      dp_in_d      = (CBC_EN && !in_dec) ? (in_block ^ chain_d) : in_block;
      out_d        = (CBC_EN && dec_q) ? (dp_o ^ chain_q) : dp_o;
      next_chain_d = dec_q ? save_q : dp_o;
      timeout_d    = (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         chain_q     <= '0;
         save_q      <= '0;
         dec_q       <= 1'b0;
         idx_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         dp_start_q  <= 1'b0;
         dp_ende_q   <= 1'b0;
         dp_block_q  <= '0;
         out_block_q <= '0;
         out_addr_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (iv_load) begin
                  chain_q <= iv;
                  idx_q   <= '0;
                  err_q   <= 1'b0;
               end
               if (in_valid) begin
                  dp_block_q <= dp_in_d;
                  save_q     <= in_block;
                  dec_q      <= in_dec;
                  dp_ende_q  <= in_dec;
                  dp_start_q <= 1'b1;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= S_START;
               end
            end
            S_START: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (dp_busy) begin
                  dp_start_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= S_ACK;
               end else if (timeout_d) begin
                  err_q      <= 1'b1;
                  dp_start_q <= 1'b0;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_ACK: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (!dp_busy) begin
                  state_q <= S_DONE;
               end else if (timeout_d) begin
                  err_q      <= 1'b1;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_DONE: begin
               out_block_q <= out_d;
               out_addr_q  <= idx_q;
               if (CBC_EN) begin
                  chain_q <= next_chain_d;
               end
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  idx_q       <= idx_q + ADDR_W'(1);
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
               dp_start_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_block   = out_block_q;
   assign out_addr    = out_addr_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign dp_rst      = ~Reset_n;
   assign dp_start    = dp_start_q;
   assign dp_ende     = dp_ende_q;
   assign dp_block    = dp_block_q;
   assign dp_key      = key;
   assign dp_addr     = idx_q;

endmodule
`default_nettype wire
